// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared encodings for the multicycle CPU: instruction opcodes, ALU function
// codes, PC-source mux codes and the control FSM state encoding. Imported by
// multicycle_control and by the datapath so both sides agree on every code.
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Instruction opcodes, IR bits [15:12]. Codes 9..E are illegal.
    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_ADDI = 4'h4,
        OP_LW   = 4'h5,
        OP_SW   = 4'h6,
        OP_BEQ  = 4'h7,
        OP_JMP  = 4'h8,
        OP_HALT = 4'hF
    } opcode_e;

    // ALU function select. R-type opcodes 0..3 map directly onto these codes.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3
    } alu_op_e;

    // PC input mux select.
    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_src_e;

    // Control FSM states (binary encoded; codes 6 and 7 are unused).
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Control FSM for a multicycle CPU: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Memory accesses in FETCH and MEM are guarded by a wait counter; if
// mem_ready does not arrive in time the request is dropped for one cycle, a
// sticky fault is raised and FETCH restarts. Illegal opcodes also raise the
// fault. HALT is absorbing until rst.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   opcode[3:0]   IR[15:12] from the datapath
//   zero          ALU zero flag, used in EXEC for BEQ
//   mem_ready     completion strobe for the current memory request
//   pc_write      load PC
//   pc_src[1:0]   PC mux select (PC+1 / branch / jump)
//   ir_write      load instruction register
//   mem_req       memory request, held until mem_ready
//   mem_we        write qualifier for mem_req
//   mem_addr_sel  memory address: 0 = PC, 1 = ALU result
//   alu_op[2:0]   ALU function
//   alu_src_imm   ALU B operand is the sign-extended immediate
//   reg_write     register-file write strobe
//   wb_sel        write-back source: 0 = ALU, 1 = memory data
//   halted        FSM is in HALT
//   fault         sticky memory-timeout / illegal-opcode flag
// Outputs are decoded combinationally from state and opcode, with mem_ready
// and zero as the only Mealy terms; fault is the sticky register itself.
// ---------------------------------------------------------------------------
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic [2:0] alu_op,
    output logic       alu_src_imm,
    output logic       reg_write,
    output logic       wb_sel,
    output logic       halted,
    output logic       fault
);

    localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    state_e           state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             fault_r;
    logic             wait_expired_s;

    // Access gives up on the WAIT_MAX cycle only if mem_ready is still low;
    // a ready on that very cycle is still a successful completion.
    assign wait_expired_s = (wait_cnt_r == CNT_MAX) && !mem_ready;

    assign fault = fault_r;

    // State, wait counter and sticky fault register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= '0;
            fault_r    <= 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (mem_ready) begin
                        state_r    <= S_DECODE;
                        wait_cnt_r <= '0;
                    end else if (wait_expired_s) begin
                        // Re-enter FETCH at the same PC (no pc_write issued).
                        state_r    <= S_FETCH;
                        wait_cnt_r <= '0;
                        fault_r    <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    wait_cnt_r <= '0;
                    case (opcode)
                        OP_HALT: state_r <= S_HALT;
                        OP_JMP:  state_r <= S_FETCH;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
                        OP_LW, OP_SW, OP_BEQ: state_r <= S_EXEC;
                        default: begin
                            // Illegal opcode: flag it and carry on fetching.
                            fault_r <= 1'b1;
                            state_r <= S_FETCH;
                        end
                    endcase
                end
                S_EXEC: begin
                    wait_cnt_r <= '0;
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_r <= S_WB;
                        OP_LW, OP_SW:                           state_r <= S_MEM;
                        default:                                state_r <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        wait_cnt_r <= '0;
                        if (opcode == OP_LW) begin
                            state_r <= S_WB;
                        end else begin
                            state_r <= S_FETCH;
                        end
                    end else if (wait_expired_s) begin
                        state_r    <= S_FETCH;
                        wait_cnt_r <= '0;
                        fault_r    <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                S_WB: begin
                    wait_cnt_r <= '0;
                    state_r    <= S_FETCH;
                end
                S_HALT: begin
                    wait_cnt_r <= '0;
                    state_r    <= S_HALT;
                end
                default: begin
                    wait_cnt_r <= '0;
                    state_r    <= S_FETCH;
                end
            endcase
        end
    end

    // Output decode; everything is held low while rst is asserted so an
    // in-flight memory request is withdrawn immediately.
    always_comb begin
        pc_write     = 1'b0;
        pc_src       = PC_INC;
        ir_write     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_op       = ALU_ADD;
        alu_src_imm  = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 1'b0;
        halted       = 1'b0;
        if (rst) begin
            halted = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    mem_req = !wait_expired_s;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_INC;
                    end else begin
                        ir_write = 1'b0;
                    end
                end
                S_DECODE: begin
                    if (opcode == OP_JMP) begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                    end else begin
                        pc_write = 1'b0;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR: alu_op = opcode[2:0];
                        OP_ADDI, OP_LW, OP_SW: begin
                            alu_op      = ALU_ADD;
                            alu_src_imm = 1'b1;
                        end
                        OP_BEQ: begin
                            alu_op   = ALU_SUB;
                            pc_src   = PC_BRANCH;
                            pc_write = zero;
                        end
                        default: alu_op = ALU_ADD;
                    endcase
                end
                S_MEM: begin
                    // The address select stays on the ALU result even in the
                    // timeout cycle; only the request and its qualifier drop.
                    mem_addr_sel = 1'b1;
                    mem_req      = !wait_expired_s;
                    mem_we       = !wait_expired_s && (opcode == OP_SW);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = (opcode == OP_LW);
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Builds a cycle-by-cycle plan from an instruction-level reference model
// (phases per instruction, access delays, sticky fault), drives it into the
// DUT, and a separate monitor compares every output cycle against the
// expected vector queued by the driver.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int WAIT_MAX = 15;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       reg_write;
    logic       wb_sel;
    logic       halted;
    logic       fault;

    multicycle_control #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .ir_write     (ir_write),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .alu_op       (alu_op),
        .alu_src_imm  (alu_src_imm),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .fault        (fault)
    );

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic [2:0] alu_op;
        logic       alu_src_imm;
        logic       reg_write;
        logic       wb_sel;
        logic       halted;
        logic       fault;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [3:0] op;
        logic       z;
        logic       rdy;
        outs_t      exp;
    } cyc_t;

    cyc_t       plan[$];
    outs_t      sb[$];
    logic       fault_m;
    logic [3:0] ir_m;
    int         checks;
    int         errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rnd();
        return 1'($urandom_range(1, 0));
    endfunction

    // Expected vector with every strobe low and the model's sticky fault.
    function automatic outs_t idle();
        outs_t o;
        o       = '0;
        o.fault = fault_m;
        return o;
    endfunction

    task automatic push(input logic r, input logic rdy, input logic z, input outs_t e);
        cyc_t c;
        c.rst = r;
        c.op  = ir_m;
        c.z   = z;
        c.rdy = rdy;
        c.exp = e;
        plan.push_back(c);
    endtask

    // One memory access (instruction fetch or data access) that completes
    // after d idle cycles, or times out when d exceeds WAIT_MAX.
    task automatic gen_access(input int d, input logic is_mem, input logic we, output logic ok);
        outs_t e;
        ok = 1'b0;
        for (int i = 0; i <= WAIT_MAX; i++) begin
            e = idle();
            e.mem_addr_sel = is_mem;
            if (i == d) begin
                e.mem_req = 1'b1;
                e.mem_we  = we;
                if (!is_mem) begin
                    e.ir_write = 1'b1;
                    e.pc_write = 1'b1;
                end
                push(1'b0, 1'b1, rnd(), e);
                ok = 1'b1;
                break;
            end else if (i == WAIT_MAX) begin
                push(1'b0, 1'b0, rnd(), e);
                fault_m = 1'b1;
            end else begin
                e.mem_req = 1'b1;
                e.mem_we  = we;
                push(1'b0, 1'b0, rnd(), e);
            end
        end
    endtask

    task automatic gen_wb(input logic [3:0] op);
        outs_t e;
        e = idle();
        e.reg_write = 1'b1;
        e.wb_sel    = (op == 4'h5);
        push(1'b0, rnd(), rnd(), e);
    endtask

    // One complete instruction: fetch (retried after a timeout), decode and
    // whatever execute / memory / write-back phases the opcode needs.
    task automatic gen_instr(input logic [3:0] op, input int df, input int dm, input logic z);
        outs_t e;
        logic  ok;
        gen_access(df, 1'b0, 1'b0, ok);
        while (!ok) gen_access($urandom_range(3, 0), 1'b0, 1'b0, ok);
        ir_m = op;
        e = idle();
        if (op == 4'hF) begin
            push(1'b0, rnd(), rnd(), e);
            return;
        end
        if (op >= 4'h9) begin
            push(1'b0, rnd(), rnd(), e);
            fault_m = 1'b1;
            return;
        end
        if (op == 4'h8) begin
            e.pc_write = 1'b1;
            e.pc_src   = 2'd2;
            push(1'b0, rnd(), rnd(), e);
            return;
        end
        push(1'b0, rnd(), rnd(), e);
        e = idle();
        if (op <= 4'h3) begin
            e.alu_op = op[2:0];
            push(1'b0, rnd(), rnd(), e);
            gen_wb(op);
        end else if (op == 4'h4) begin
            e.alu_src_imm = 1'b1;
            push(1'b0, rnd(), rnd(), e);
            gen_wb(op);
        end else if (op == 4'h7) begin
            e.alu_op   = 3'd1;
            e.pc_src   = 2'd1;
            e.pc_write = z;
            push(1'b0, rnd(), z, e);
        end else begin
            e.alu_src_imm = 1'b1;
            push(1'b0, rnd(), rnd(), e);
            gen_access(dm, 1'b1, (op == 4'h6), ok);
            if (ok && op == 4'h5) gen_wb(op);
        end
    endtask

    task automatic gen_reset();
        outs_t e;
        e       = '0;
        e.fault = fault_m;
        push(1'b1, rnd(), rnd(), e);
        fault_m = 1'b0;
    endtask

    task automatic gen_halt(input int n);
        outs_t e;
        for (int i = 0; i < n; i++) begin
            e = idle();
            e.halted = 1'b1;
            push(1'b0, rnd(), rnd(), e);
        end
    endtask

    // Store that is abandoned by reset after k cycles of waiting in MEM.
    task automatic gen_sw_reset(input int k);
        outs_t e;
        logic  ok;
        gen_access(0, 1'b0, 1'b0, ok);
        ir_m = 4'h6;
        e = idle();
        push(1'b0, rnd(), rnd(), e);
        e.alu_src_imm = 1'b1;
        push(1'b0, rnd(), rnd(), e);
        for (int i = 0; i < k; i++) begin
            e = idle();
            e.mem_req      = 1'b1;
            e.mem_we       = 1'b1;
            e.mem_addr_sel = 1'b1;
            push(1'b0, 1'b0, rnd(), e);
        end
        gen_reset();
    endtask

    function automatic int pick_delay();
        int r;
        r = $urandom_range(19, 0);
        if (r < 16)      return r % 4;
        else if (r < 18) return WAIT_MAX;
        else             return WAIT_MAX + 1;
    endfunction

    // Monitor: one scoreboard entry is consumed per clock cycle.
    always @(negedge clk) begin
        outs_t act;
        outs_t exp;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            act = {pc_write, pc_src, ir_write, mem_req, mem_we, mem_addr_sel,
                   alu_op, alu_src_imm, reg_write, wb_sel, halted, fault};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL outputs t=%0t actual=%b required=%b (pcw,pcsrc,irw,req,we,asel,aluop,imm,regw,wbsel,halted,fault)",
                         $time, act, exp);
            end
        end
    end

    // Driver: build the plan, then apply one cycle per clock.
    initial begin
        cyc_t c;
        checks    = 0;
        errors    = 0;
        fault_m   = 1'b0;
        ir_m      = 4'h0;
        rst       = 1'b1;
        opcode    = 4'h0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        gen_reset();
        gen_instr(4'h0, 0, 0, 1'b0);              // ADD, back-to-back ready
        gen_instr(4'h5, 0, 3, 1'b0);              // LW, data ready 3 cycles late
        gen_instr(4'h7, 0, 0, 1'b1);              // BEQ taken
        gen_instr(4'h7, 0, 0, 1'b0);              // BEQ not taken
        gen_instr(4'h8, 1, 0, 1'b0);              // JMP
        gen_instr(4'h6, 1, 2, 1'b0);              // SW
        gen_instr(4'h4, 2, 0, 1'b0);              // ADDI
        gen_instr(4'h1, WAIT_MAX, 0, 1'b0);       // ready on the last allowed cycle
        gen_instr(4'h2, WAIT_MAX + 1, 0, 1'b0);   // fetch timeout, then refetch
        gen_reset();
        gen_instr(4'h9, 0, 0, 1'b0);              // illegal opcode
        gen_sw_reset(2);                          // reset during store wait
        gen_instr(4'h3, 0, 0, 1'b0);
        gen_instr(4'h5, 0, WAIT_MAX + 1, 1'b0);   // data access timeout
        for (int i = 0; i < 120; i++) begin
            gen_instr(4'($urandom_range(14, 0)), pick_delay(), pick_delay(), rnd());
        end
        gen_reset();
        gen_instr(4'hF, 0, 0, 1'b0);              // HALT
        gen_halt(20);
        gen_reset();
        gen_instr(4'h0, 0, 0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        while (plan.size() > 0) begin
            c         = plan.pop_front();
            rst       = c.rst;
            opcode    = c.op;
            zero      = c.z;
            mem_ready = c.rdy;
            sb.push_back(c.exp);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
